// File: rtl/daisy_host_seq.sv
// daisy_host_seq: host-side sequencer for the daisy responder bus.
// Issues a command/argument write pair, polls the status port for HOST_RECV,
// then reads the data port; a probe request reads only the printer-status port.
// Every access holds sel high for one bus (ce) cycle, followed by a one-ce-cycle gap.
// Build option: DAISY_POLL_TIMEOUT_EN -- when defined, status polling retries up
// to POLL_LIMIT reads; when undefined, a single status read decides the outcome
// and no poll counter is built.
module daisy_host_seq #(
   parameter int POLL_LIMIT = 16
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       ce,
   input  logic       start,
   input  logic       probe,
   input  logic [7:0] cmd,
   input  logic [7:0] arg,
   output logic       busy,
   output logic       done,
   output logic       has_data,
   output logic [7:0] result,
   output logic       sel,
   output logic [1:0] address,
   output logic       wr,
   output logic [7:0] bus_dout,
   input  logic [7:0] bus_din
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_CMD  = 3'd1;
   localparam logic [2:0] WR_ARG  = 3'd2;
   localparam logic [2:0] RD_STAT = 3'd3;
   localparam logic [2:0] RD_DATA = 3'd4;
   localparam logic [2:0] RD_PRN  = 3'd5;
   localparam logic [2:0] GAP     = 3'd6;
   localparam logic [2:0] FIN     = 3'd7;

   localparam logic [7:0] HOST_RECV = 8'hCA;
   localparam logic [7:0] NO_REPLY  = 8'hFF;

   // Responder port map: 10 = 0x1FC, 00 = 0xFC, 01 = 0xFD
   localparam logic [1:0] ADDR_1FC = 2'b10;
   localparam logic [1:0] ADDR_FC  = 2'b00;
   localparam logic [1:0] ADDR_FD  = 2'b01;

   // Reject unusable poll limits at elaboration time
   if ((POLL_LIMIT < 1) || (POLL_LIMIT > 255)) begin : g_poll_limit_range
      $error("daisy_host_seq: POLL_LIMIT must be within 1..255");
   end

   logic [2:0] state_r;
   logic [2:0] ret_r;
   logic [7:0] cmd_r;
   logic [7:0] arg_r;
   logic       busy_r;
   logic       done_r;
   logic       has_data_r;
   logic [7:0] result_r;
   logic       sel_r;
   logic [1:0] address_r;
   logic       wr_r;
   logic [7:0] bus_dout_r;

   logic [2:0] next_state_s;
   logic [2:0] next_ret_s;
   logic       next_sel_s;
   logic [1:0] next_address_s;
   logic       next_wr_s;
   logic [7:0] next_dout_s;
   logic       start_ok_s;
   logic       stat_miss_s;
   logic       poll_last_s;

   assign start_ok_s  = (state_r == IDLE) && start;
   assign stat_miss_s = (state_r == RD_STAT) && ce && (bus_din != HOST_RECV);

`ifdef DAISY_POLL_TIMEOUT_EN
   localparam logic [7:0] POLL_LAST_C = 8'(POLL_LIMIT - 1);

   logic [7:0] poll_cnt_r;

   assign poll_last_s = (poll_cnt_r >= POLL_LAST_C);

   // Poll counter: cleared at start, counts status reads that missed HOST_RECV
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         poll_cnt_r <= 8'd0;
      end else if (start_ok_s) begin
         poll_cnt_r <= 8'd0;
      end else if (stat_miss_s) begin
         poll_cnt_r <= poll_cnt_r + 8'd1;
      end else begin
         poll_cnt_r <= poll_cnt_r;
      end
   end
`else
   // Single status read: the first miss is always the last one
   assign poll_last_s = 1'b1;
`endif

   // Next-state decode; GAP returns to the access remembered in ret_r
   always_comb begin
      next_state_s = state_r;
      next_ret_s   = ret_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_state_s = probe ? RD_PRN : WR_CMD;
            end else begin
               next_state_s = IDLE;
            end
         end
         WR_CMD: begin
            if (ce) begin
               next_state_s = GAP;
               next_ret_s   = WR_ARG;
            end else begin
               next_state_s = WR_CMD;
            end
         end
         WR_ARG: begin
            if (ce) begin
               next_state_s = GAP;
               next_ret_s   = RD_STAT;
            end else begin
               next_state_s = WR_ARG;
            end
         end
         RD_STAT: begin
            if (ce) begin
               next_state_s = GAP;
               if (bus_din == HOST_RECV) begin
                  next_ret_s = RD_DATA;
               end else if (poll_last_s) begin
                  next_ret_s = FIN;
               end else begin
                  next_ret_s = RD_STAT;
               end
            end else begin
               next_state_s = RD_STAT;
            end
         end
         RD_DATA, RD_PRN: begin
            if (ce) begin
               next_state_s = GAP;
               next_ret_s   = FIN;
            end else begin
               next_state_s = state_r;
            end
         end
         GAP: begin
            if (ce) begin
               next_state_s = ret_r;
            end else begin
               next_state_s = GAP;
            end
         end
         FIN: begin
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
            next_ret_s   = IDLE;
         end
      endcase
   end

   // Bus drive values for the state being entered; WR_CMD is entered straight
   // from IDLE, before cmd_r has been loaded, so it takes cmd directly then
   always_comb begin
      next_sel_s     = 1'b0;
      next_address_s = ADDR_FC;
      next_wr_s      = 1'b0;
      next_dout_s    = 8'h00;
      case (next_state_s)
         WR_CMD: begin
            next_sel_s     = 1'b1;
            next_address_s = ADDR_1FC;
            next_wr_s      = 1'b1;
            if (state_r == IDLE) begin
               next_dout_s = cmd;
            end else begin
               next_dout_s = cmd_r;
            end
         end
         WR_ARG: begin
            next_sel_s     = 1'b1;
            next_address_s = ADDR_FC;
            next_wr_s      = 1'b1;
            next_dout_s    = arg_r;
         end
         RD_STAT: begin
            next_sel_s     = 1'b1;
            next_address_s = ADDR_FD;
         end
         RD_DATA: begin
            next_sel_s     = 1'b1;
            next_address_s = ADDR_FC;
         end
         RD_PRN: begin
            next_sel_s     = 1'b1;
            next_address_s = ADDR_1FC;
         end
         default: begin
            next_sel_s     = 1'b0;
            next_address_s = ADDR_FC;
            next_wr_s      = 1'b0;
            next_dout_s    = 8'h00;
         end
      endcase
   end

   // State, handshake flags and registered bus outputs
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         ret_r      <= IDLE;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         sel_r      <= 1'b0;
         address_r  <= ADDR_FC;
         wr_r       <= 1'b0;
         bus_dout_r <= 8'h00;
      end else begin
         state_r    <= next_state_s;
         ret_r      <= next_ret_s;
         busy_r     <= (next_state_s != IDLE) && (next_state_s != FIN);
         done_r     <= (next_state_s == FIN);
         sel_r      <= next_sel_s;
         address_r  <= next_address_s;
         wr_r       <= next_wr_s;
         bus_dout_r <= next_dout_s;
      end
   end

   // Request latch: command and argument are captured only when a start is accepted
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         cmd_r <= 8'h00;
         arg_r <= 8'h00;
      end else if (start_ok_s) begin
         cmd_r <= cmd;
         arg_r <= arg;
      end else begin
         cmd_r <= cmd_r;
         arg_r <= arg_r;
      end
   end

   // Result capture: data/printer reads, or the no-reply marker on poll exhaustion
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         result_r   <= 8'h00;
         has_data_r <= 1'b0;
      end else if (stat_miss_s && poll_last_s) begin
         result_r   <= NO_REPLY;
         has_data_r <= 1'b0;
      end else if ((state_r == RD_DATA) && ce) begin
         result_r   <= bus_din;
         has_data_r <= 1'b1;
      end else if ((state_r == RD_PRN) && ce) begin
         result_r   <= bus_din;
         has_data_r <= 1'b0;
      end else begin
         result_r   <= result_r;
         has_data_r <= has_data_r;
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign has_data = has_data_r;
   assign result   = result_r;
   assign sel      = sel_r;
   assign address  = address_r;
   assign wr       = wr_r;
   assign bus_dout = bus_dout_r;

endmodule

// File: tb/tb_daisy_host_seq.sv
// tb_daisy_host_seq: directed self-checking bench for daisy_host_seq.
// A behavioural responder answers reads by address; a monitor logs every
// completed access (sel high on a ce cycle) as {wr, address, bus_dout}.
module tb_daisy_host_seq;

   localparam int POLL_LIMIT = 4;
`ifdef DAISY_POLL_TIMEOUT_EN
   localparam int EXP_POLLS = 4;
`else
   localparam int EXP_POLLS = 1;
`endif

   logic       clk_sys = 1'b0;
   logic       reset_n = 1'b0;
   logic       ce      = 1'b1;
   logic       start   = 1'b0;
   logic       probe   = 1'b0;
   logic [7:0] cmd     = 8'h00;
   logic [7:0] arg     = 8'h00;
   logic       busy;
   logic       done;
   logic       has_data;
   logic [7:0] result;
   logic       sel;
   logic [1:0] address;
   logic       wr;
   logic [7:0] bus_dout;
   logic [7:0] bus_din;

   // responder contents
   logic [7:0] stat_v = 8'hCA;
   logic [7:0] data_v = 8'h00;
   logic [7:0] prn_v  = 8'h00;

   bit         ce_div  = 1'b0;
   int         div_cnt = 0;

   int         n_cmp   = 0;
   int         n_bad   = 0;
   int         n_acc   = 0;
   int         n_done  = 0;
   int         gap_err = 0;
   logic       prev_sel_ce = 1'b0;
   logic [10:0] acc_log [0:31];

   always #5 clk_sys = ~clk_sys;

   assign bus_din = (sel && !wr) ? ((address == 2'b01) ? stat_v :
                                    (address == 2'b10) ? prn_v  : data_v) : 8'h00;

   daisy_host_seq #(.POLL_LIMIT(POLL_LIMIT)) dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .ce      (ce),
      .start   (start),
      .probe   (probe),
      .cmd     (cmd),
      .arg     (arg),
      .busy    (busy),
      .done    (done),
      .has_data(has_data),
      .result  (result),
      .sel     (sel),
      .address (address),
      .wr      (wr),
      .bus_dout(bus_dout),
      .bus_din (bus_din)
   );

   // ce generator: constant 1, or one cycle in four
   always @(negedge clk_sys) begin
      if (ce_div) begin
         ce = (div_cnt == 0);
         div_cnt = (div_cnt + 1) % 4;
      end else begin
         ce = 1'b1;
      end
   end

   // access monitor: logs completed accesses and flags back-to-back sel ce cycles
   always @(posedge clk_sys) begin
      if (reset_n) begin
         if (done) n_done++;
         if (ce) begin
            if (sel) begin
               if (prev_sel_ce) gap_err++;
               if (n_acc < 32) acc_log[n_acc] = {wr, address, bus_dout};
               n_acc++;
            end
            prev_sel_ce = sel;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k;
      k = 0;
      while ((done !== 1'b1) && (k < budget)) begin
         @(negedge clk_sys);
         k++;
      end
      if (done !== 1'b1) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   // start a transaction, then scramble the request inputs while busy
   task automatic launch(input logic p, input logic [7:0] c, input logic [7:0] a);
      @(negedge clk_sys);
      n_acc  = 0;
      n_done = 0;
      probe  = p;
      cmd    = c;
      arg    = a;
      start  = 1'b1;
      @(negedge clk_sys);
      start  = 1'b0;
      probe  = 1'b0;
      cmd    = 8'hEE;
      arg    = 8'hEE;
   endtask

   // checks taken in the done cycle and just after it
   task automatic expect_end(input string tag, input logic [7:0] res, input logic hd, input int nacc);
      check_eq({tag, "_result"}, {24'd0, result}, {24'd0, res});
      check_eq({tag, "_has_data"}, {31'd0, has_data}, {31'd0, hd});
      check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_accesses"}, n_acc, nacc);
      @(negedge clk_sys);
      check_eq({tag, "_done_pulses"}, n_done, 32'd1);
      check_eq({tag, "_done_width"}, {31'd0, done}, 32'd0);
   endtask

   logic [10:0] exp_seq [0:3];

   initial begin
      // ---- reset state
      start = 1'b1;
      repeat (3) @(negedge clk_sys);
      start = 1'b0;
      reset_n = 1'b1;
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_result", {23'd0, has_data, result}, 32'd0);
      check_eq("rst_bus", {20'd0, sel, wr, address, bus_dout}, 32'd0);

      // ---- normal transaction: status HOST_RECV, data 0x00
      stat_v = 8'hCA; data_v = 8'h00;
      launch(1'b0, 8'h12, 8'h00);
      wait_done("txn12", 200);
      expect_end("txn12", 8'h00, 1'b1, 4);
      exp_seq[0] = 11'h612; exp_seq[1] = 11'h400; exp_seq[2] = 11'h100; exp_seq[3] = 11'h000;
      for (int i = 0; i < 4; i++) check_eq($sformatf("txn12_acc%0d", i), {21'd0, acc_log[i]}, {21'd0, exp_seq[i]});

      // ---- reference run with ce=1, cmd 0x0a
      data_v = 8'h5A;
      launch(1'b0, 8'h0A, 8'h01);
      wait_done("txn0a", 200);
      expect_end("txn0a", 8'h5A, 1'b1, 4);

      // ---- same request with ce pulsed one cycle in four
      ce_div = 1'b1;
      gap_err = 0;
      launch(1'b0, 8'h0A, 8'h01);
      wait_done("slow0a", 400);
      expect_end("slow0a", 8'h5A, 1'b1, 4);
      check_eq("slow0a_gap", gap_err, 32'd0);
      check_eq("slow0a_acc0", {21'd0, acc_log[0]}, 32'h60A);
      check_eq("slow0a_acc1", {21'd0, acc_log[1]}, 32'h401);
      ce_div = 1'b0;

      // ---- status never HOST_RECV: poll exhaustion
      stat_v = 8'hE9;
      launch(1'b0, 8'h05, 8'h33);
      wait_done("poll", 400);
      expect_end("poll", 8'hFF, 1'b0, 2 + EXP_POLLS);
      check_eq("poll_acc0", {21'd0, acc_log[0]}, 32'h605);
      check_eq("poll_acc1", {21'd0, acc_log[1]}, 32'h433);
      check_eq("poll_last_rd", {21'd0, acc_log[1 + EXP_POLLS]}, 32'h100);

      // ---- probe: single printer-status read
      prn_v = 8'h40;
      launch(1'b1, 8'h12, 8'h34);
      wait_done("probe", 200);
      expect_end("probe", 8'h40, 1'b0, 1);
      check_eq("probe_acc0", {21'd0, acc_log[0]}, 32'h200);

      // ---- reset during WR_ARG
      stat_v = 8'hCA; data_v = 8'h3C;
      launch(1'b0, 8'h12, 8'h00);
      begin
         int k;
         k = 0;
         while (!(sel && wr && (address == 2'b00)) && (k < 50)) begin
            @(negedge clk_sys);
            k++;
         end
         check_eq("abort_reached_wr_arg", {31'd0, (sel && wr && (address == 2'b00))}, 32'd1);
      end
      reset_n = 1'b0;
      @(negedge clk_sys);
      check_eq("abort_sel", {31'd0, sel}, 32'd0);
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_result", {24'd0, result}, 32'd0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk_sys);
      check_eq("abort_no_done", n_done, 32'd0);
      launch(1'b0, 8'h0A, 8'h01);
      wait_done("after_abort", 200);
      expect_end("after_abort", 8'h3C, 1'b1, 4);

      // ---- start held high across a whole transaction
      @(negedge clk_sys);
      n_acc = 0; n_done = 0;
      data_v = 8'h77;
      cmd = 8'h12; arg = 8'h00; start = 1'b1;
      wait_done("hold1", 200);
      check_eq("hold1_accesses", n_acc, 32'd4);
      check_eq("hold1_result", {24'd0, result}, 32'h77);
      check_eq("hold1_busy_fin", {31'd0, busy}, 32'd0);
      cmd = 8'h34; arg = 8'h56;
      @(negedge clk_sys);
      check_eq("hold_fin_start_ignored", {31'd0, busy}, 32'd0);
      @(negedge clk_sys);
      check_eq("hold2_started", {31'd0, busy}, 32'd1);
      start = 1'b0;
      wait_done("hold2", 200);
      check_eq("hold2_accesses", n_acc, 32'd8);
      check_eq("hold2_acc0", {21'd0, acc_log[4]}, 32'h634);
      check_eq("hold2_acc1", {21'd0, acc_log[5]}, 32'h456);
      @(negedge clk_sys);
      check_eq("hold_done_pulses", n_done, 32'd2);

      check_eq("gap_overall", gap_err, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/daisy_host_seq.md
DAISY_HOST_SEQ -- requirements
Module: daisy_host_seq

Interface
REQ-001 SHALL have parameter POLL_LIMIT, default 16, max status reads per transaction (1..255).
REQ-002 SHALL have port clk_sys  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port ce  input  1  bus clock enable; bus state advances only when ce=1.
REQ-005 SHALL have port start  input  1  request a transaction, sampled in IDLE.
REQ-006 SHALL have port probe  input  1  with start: read printer-status port only.
REQ-007 SHALL have port cmd  input  8  command byte, latched at start.
REQ-008 SHALL have port arg  input  8  argument byte, latched at start.
REQ-009 SHALL have port busy  output  1  transaction in progress.
REQ-010 SHALL have port done  output  1  one-clk_sys pulse at transaction end.
REQ-011 SHALL have port has_data  output  1  result came from data port (valid with done).
REQ-012 SHALL have port result  output  8  returned byte, held until next start.
REQ-013 SHALL have ports sel (output, 1), address (output, 2), wr (output, 1), bus_dout (output, 8), bus_din (input, 8): responder bus; address 10=0x1FC, 00=0xFC, 01=0xFD.

Function
REQ-014 SHALL use states IDLE, WR_CMD, WR_ARG, RD_STAT, RD_DATA, RD_PRN, GAP, FIN.
REQ-015 In IDLE, start=1 SHALL latch cmd/arg/probe, set busy=1, and enter WR_CMD (RD_PRN if probe=1) on the next clk_sys edge, regardless of ce.
REQ-016 Each access state SHALL drive sel=1 for exactly one ce=1 cycle, followed by GAP with sel=0 for exactly one ce=1 cycle, so the responder sees one sel rising edge per access.
REQ-017 WR_CMD SHALL drive wr=1, address=10, bus_dout=cmd; WR_ARG SHALL drive wr=1, address=00, bus_dout=arg.
REQ-018 RD_STAT SHALL drive wr=0, address=01 and sample bus_din on its ce cycle.
REQ-019 Status 0xCA (HOST_RECV) SHALL lead to RD_DATA; any other value SHALL count one poll and repeat RD_STAT until the poll limit is reached.
REQ-020 RD_DATA SHALL drive wr=0, address=00; sampled bus_din SHALL go to result, with has_data=1.
REQ-021 When the poll limit is reached without 0xCA, SHALL set result=0xFF, has_data=0, and go to FIN.
REQ-022 RD_PRN SHALL drive wr=0, address=10; result=bus_din, has_data=0.
REQ-023 FIN SHALL pulse done for one clk_sys, clear busy, and return to IDLE; start in that cycle SHALL be ignored.
REQ-024 start while busy=1 SHALL be ignored; cmd/arg changes mid-transaction SHALL have no effect.
REQ-025 Outside access states, sel=0, wr=0, address=00, bus_dout=0x00.
REQ-026 ce=0 SHALL freeze state, bus outputs and the poll counter.
REQ-027 The poll counter SHALL be 8 bits and SHALL clear at each start.

Reset
REQ-028 reset_n=0 at a clk_sys edge SHALL force IDLE, sel=0, wr=0, address=00, bus_dout=0x00, busy=0, done=0, has_data=0, result=0x00, poll counter=0, independent of ce.
REQ-029 Reset mid-transaction SHALL abort it with no done pulse; sel SHALL be 0 in the first cycle after the reset edge.

Configuration
REQ-030 With DAISY_POLL_TIMEOUT_EN defined, the poll limit SHALL be POLL_LIMIT reads.
REQ-031 Without DAISY_POLL_TIMEOUT_EN, the poll limit SHALL be exactly one status read, POLL_LIMIT SHALL be ignored, and the counter logic SHALL be absent.

Verification
REQ-032 ce=1 constant, start cmd=0x12 arg=0x00, responder returns status 0xCA and data 0x00 -> bus sequence: write 1FC=0x12, write FC=0x00, read FD, read FC; done with has_data=1, result=0x00.
REQ-033 cmd=0x05 arg=0x33, responder returns status 0xE9 -> with macro and POLL_LIMIT=4: 4 FD reads, then done with has_data=0, result=0xFF; without macro: 1 FD read, same result.
REQ-034 probe=1, responder returns 0x40 at 1FC -> single read at address 10, done with result=0x40, has_data=0, and no write cycles.
REQ-035 ce pulsed 1-in-4, cmd=0x0a -> every sel high lasts exactly one ce cycle with a one-ce-cycle gap; result matches the ce=1 run.
REQ-036 reset_n=0 during WR_ARG -> next cycle sel=0, busy=0, no done pulse; a new start then completes normally.
REQ-037 start held high through a whole transaction -> a second transaction begins only after the FIN cycle, not during busy.
